// File: rtl/mem_bus_arbiter.sv
// Arbitrates 4-beat block bursts from the instruction and data cache controllers
// onto a single external memory bus, alternating grants when both request.
module mem_bus_arbiter #(
  parameter int ADDRW = 32,
  parameter int DATAW = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             HRequestF,
  input  logic [ADDRW-1:0] HAddrF,
  input  logic             HRequestM,
  input  logic             HWriteM,
  input  logic [ADDRW-1:0] HAddrM,
  input  logic [DATAW-1:0] HWDataM,
  output logic             BusReadyF,
  output logic             BusReadyM,
  output logic [DATAW-1:0] HRData,
  output logic             HREQ,
  output logic             HWRITE,
  output logic [ADDRW-1:0] HADDR,
  output logic [DATAW-1:0] HWDATA,
  input  logic             HREADY,
  input  logic [DATAW-1:0] HRDATA
);

  typedef enum logic [1:0] {IDLE, FBURST, MBURST} state_t;

  state_t           state_q, state_d;
  logic [1:0]       beat_q, beat_d;
  logic             lastm_q, lastm_d;
  logic [ADDRW-5:0] gaddr_q, gaddr_d;
  logic             gwrite_q, gwrite_d;
  logic             granted_req;
  logic             unused_addr_lsbs;

  assign unused_addr_lsbs = ^{HAddrF[3:0], HAddrM[3:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      lastm_q  <= 1'b0;
      gaddr_q  <= '0;
      gwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      lastm_q  <= lastm_d;
      gaddr_q  <= gaddr_d;
      gwrite_q <= gwrite_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    lastm_d     = lastm_q;
    gaddr_d     = gaddr_q;
    gwrite_d    = gwrite_q;
    granted_req = 1'b0;
    BusReadyF   = 1'b0;
    BusReadyM   = 1'b0;
    HREQ        = 1'b0;
    HWRITE      = 1'b0;
    HADDR       = '0;
    HWDATA      = '0;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        // On contention the data cache wins unless it was the last one served.
        if (HRequestM && (!HRequestF || !lastm_q)) begin
          state_d  = MBURST;
          gaddr_d  = HAddrM[ADDRW-1:4];
          gwrite_d = HWriteM;
          lastm_d  = 1'b1;
        end else if (HRequestF) begin
          state_d  = FBURST;
          gaddr_d  = HAddrF[ADDRW-1:4];
          gwrite_d = 1'b0;
          lastm_d  = 1'b0;
        end
      end
      FBURST, MBURST: begin
        granted_req = (state_q == MBURST) ? HRequestM : HRequestF;
        HREQ        = 1'b1;
        HWRITE      = gwrite_q;
        HADDR       = {gaddr_q, beat_q, 2'b00};
        HWDATA      = (state_q == MBURST) ? HWDataM : '0;
        if (!granted_req) begin
          state_d = IDLE;
          beat_d  = '0;
        end else if (HREADY) begin
          BusReadyF = (state_q == FBURST);
          BusReadyM = (state_q == MBURST);
          beat_d    = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign HRData = reset ? HRDATA : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter: episodes of cache bursts are
// predicted as beat transactions and checked by an independent monitor.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        HRequestF = 1'b0, HRequestM = 1'b0, HWriteM = 1'b0;
  logic [31:0] HAddrF = '0, HAddrM = '0, HWDataM = '0;
  logic        BusReadyF, BusReadyM, HREQ, HWRITE;
  logic [31:0] HRData, HADDR, HWDATA;
  logic        HREADY = 1'b0;
  logic [31:0] HRDATA = '0;

  mem_bus_arbiter #(.ADDRW(32), .DATAW(32)) dut (
    .clk(clk), .reset(reset),
    .HRequestF(HRequestF), .HAddrF(HAddrF),
    .HRequestM(HRequestM), .HWriteM(HWriteM), .HAddrM(HAddrM), .HWDataM(HWDataM),
    .BusReadyF(BusReadyF), .BusReadyM(BusReadyM), .HRData(HRData),
    .HREQ(HREQ), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          m;
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wd;
    int          beat;
  } exp_t;

  exp_t q[$];
  bit   pat[$];
  int   checks = 0;
  int   errors = 0;
  bit   last_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected beats of one served burst: in order from the 16-byte block base.
  task automatic push_burst(input bit m, input logic [31:0] addr, input bit wr,
                            input logic [31:0] wd [4], input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.m    = m;
      e.addr = {addr[31:4], 4'h0} + 32'(4 * k);
      e.wr   = m ? wr : 1'b0;
      e.wd   = m ? wd[k] : 32'h0;
      e.beat = k;
      q.push_back(e);
    end
  endtask

  // Memory side: HREADY from a directed pattern when queued, else random.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (pat.size() > 0) HREADY = pat.pop_front();
      else HREADY = ($urandom_range(0, 3) != 0);
      HRDATA = $urandom;
    end
  end

  // Monitor: pops and compares an expected beat whenever a BusReady appears.
  initial begin
    exp_t e;
    bit   bub = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        bub = 1'b0;
      end else begin
        if (bub) chk("bubble_after_burst", {31'b0, HREQ}, 32'h0);
        bub = 1'b0;
        if (BusReadyF && BusReadyM) chk("both_ready", 32'h1, 32'h0);
        if (BusReadyF || BusReadyM) begin
          if (q.size() == 0) begin
            chk("unexpected_beat", {31'b0, BusReadyM}, 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("beat_side_m", {31'b0, BusReadyM}, {31'b0, e.m});
            chk("beat_haddr", HADDR, e.addr);
            chk("beat_hwrite", {31'b0, HWRITE}, {31'b0, e.wr});
            chk("beat_hwdata", HWDATA, e.wd);
            chk("beat_hrdata", HRData, HRDATA);
            if (e.beat == 3) bub = 1'b1;
          end
        end else if (HREQ && q.size() > 0) begin
          chk("stall_haddr", HADDR, q[0].addr);
          chk("stall_hwrite", {31'b0, HWRITE}, {31'b0, q[0].wr});
        end
      end
    end
  end

  // One cache controller: requests, counts its BusReady beats, drops after nb.
  task automatic run_req(input bit m, input int delay, input int nb, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wd [4], input bit chk_start);
    int cnt = 0;
    int cyc = 0;
    bit rdy;
    repeat (delay) begin @(posedge clk); #1; end
    if (m) begin
      HRequestM = 1'b1; HAddrM = addr; HWriteM = wr; HWDataM = wd[0];
    end else begin
      HRequestF = 1'b1; HAddrF = addr;
    end
    forever begin
      @(negedge clk);
      rdy = m ? BusReadyM : BusReadyF;
      if (chk_start && cyc == 0) chk("grant_registered", {31'b0, HREQ}, 32'h0);
      if (chk_start && cyc == 1) begin
        chk("first_beat_hreq", {31'b0, HREQ}, 32'h1);
        chk("first_beat_addr", HADDR, {addr[31:4], 4'h0});
      end
      @(posedge clk); #1;
      cyc++;
      if (rdy) begin
        cnt++;
        if (cnt == 1) begin
          if (m) begin HAddrM = $urandom; HWriteM = $urandom_range(0, 1); end
          else HAddrF = $urandom;
        end
        if (cnt == nb) begin
          if (m) HRequestM = 1'b0; else HRequestF = 1'b0;
          break;
        end
        if (m) HWDataM = wd[cnt];
      end
      if (cyc > 300) begin
        chk("request_timeout", 32'(cnt), 32'(nb));
        if (m) HRequestM = 1'b0; else HRequestF = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] wdf [4];
    logic [31:0] wdm [4];
    logic [31:0] af, am;
    int          kind, df, dm, nb, cnt;
    bit          wr, rdy;

    // Reset held with an instruction request pending.
    reset = 1'b0; HRequestF = 1'b1; HAddrF = 32'h104;
    repeat (3) begin
      @(negedge clk);
      chk("reset_hreq", {31'b0, HREQ}, 32'h0);
      chk("reset_readyf", {31'b0, BusReadyF}, 32'h0);
      chk("reset_hrdata", HRData, 32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) wdf[k] = '0;
    push_burst(1'b0, 32'h104, 1'b0, wdf, 4);
    last_m = 1'b0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run_req(1'b0, 0, 4, 1'b0, 32'h104, wdf, 1'b0);
    repeat (3) begin @(posedge clk); #1; end

    // Reset in the middle of a data-cache write burst.
    for (int k = 0; k < 4; k++) wdm[k] = $urandom;
    push_burst(1'b1, 32'h2000, 1'b1, wdm, 2);
    HRequestM = 1'b1; HAddrM = 32'h2000; HWriteM = 1'b1; HWDataM = wdm[0];
    cnt = 0;
    for (int c = 0; c < 300 && cnt < 2; c++) begin
      @(negedge clk); rdy = BusReadyM;
      @(posedge clk); #1;
      if (rdy) begin cnt++; HWDataM = wdm[cnt]; end
    end
    chk("midreset_beats", 32'(cnt), 32'h2);
    #2 reset = 1'b0;
    #1;
    chk("midreset_hreq", {31'b0, HREQ}, 32'h0);
    chk("midreset_hwrite", {31'b0, HWRITE}, 32'h0);
    chk("midreset_readym", {31'b0, BusReadyM}, 32'h0);
    HRequestM = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    last_m = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_reset_idle", {31'b0, HREQ}, 32'h0);
    end
    @(posedge clk); #1;

    // Episode 0 is a directed simultaneous request; the rest are random.
    for (int ep = 0; ep < 60; ep++) begin
      kind = (ep == 0) ? 2 : $urandom_range(0, 3);
      af = $urandom; am = $urandom; wr = (ep == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) begin wdf[k] = $urandom; wdm[k] = $urandom; end
      if (kind == 2) begin
        df = (ep == 0) ? 0 : $urandom_range(0, 3);
        dm = (ep == 0) ? 0 : $urandom_range(0, 3);
        if (dm < df || (dm == df && !last_m)) begin
          push_burst(1'b1, am, wr, wdm, 4); push_burst(1'b0, af, 1'b0, wdf, 4);
          last_m = 1'b0;
        end else begin
          push_burst(1'b0, af, 1'b0, wdf, 4); push_burst(1'b1, am, wr, wdm, 4);
          last_m = 1'b1;
        end
        fork
          run_req(1'b0, df, 4, 1'b0, af, wdf, 1'b0);
          run_req(1'b1, dm, 4, wr, am, wdm, 1'b0);
        join
      end else begin
        nb = (kind == 3) ? $urandom_range(1, 3) : 4;
        if (kind == 0 || (kind == 3 && (ep % 2) == 0)) begin
          push_burst(1'b0, af, 1'b0, wdf, nb);
          last_m = 1'b0;
          run_req(1'b0, 0, nb, 1'b0, af, wdf, 1'b1);
        end else begin
          push_burst(1'b1, am, wr, wdm, nb);
          last_m = 1'b1;
          run_req(1'b1, 0, nb, wr, am, wdm, 1'b1);
        end
      end
      repeat (3) begin @(posedge clk); #1; end
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
